serial_add_ctrl: RTL

Sequencer that time-multiplexes one 1-bit full-adder cell across WIDTH clock cycles to perform a WIDTH-bit add or subtract. It is the area-minimal arithmetic option for the ALU.
- Latches operands on a start handshake.
- Feeds one bit pair per cycle (LSB first) through the cell, with a registered carry.
- Shifts result bits into a result register.
- Reports completion with flags.

---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for the bit-serial add/subtract sequencer
interface serial_add_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic             i_sub;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic             o_overflow;
   logic             o_zero;

   modport master (
      output i_start, i_sub, i_a, i_b,
      input  o_busy, o_done, o_sum, o_carry, o_overflow, o_zero
   );

   modport slave (
      input  i_start, i_sub, i_a, i_b,
      output o_busy, o_done, o_sum, o_carry, o_overflow, o_zero
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - WIDTH-bit add/subtract using one full-adder cell over WIDTH cycles
module serial_add_ctrl_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_carry,
   output logic o_sum,
   output logic o_carry
);
   assign o_sum   = i_a ^ i_b ^ i_carry;
   assign o_carry = (i_a & i_b) | (i_a & i_carry) | (i_b & i_carry);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   serial_add_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] LP_MSB_IN = CNT_W'(WIDTH - 2);

   state_t           r_state;
   state_t           w_next_state;
   logic             w_load;
   logic             w_run;
   logic             w_last;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_cy;
   logic             r_cmsb;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_ovf;
   logic             r_zero;

   logic             w_fa_sum;
   logic             w_fa_cout;
   logic [WIDTH-1:0] w_res_next;

   serial_add_ctrl_fa u_fa (
      .i_a     (r_a[0]),
      .i_b     (r_b[0]),
      .i_carry (r_cy),
      .o_sum   (w_fa_sum),
      .o_carry (w_fa_cout)
   );

   assign w_res_next = {w_fa_sum, r_res[WIDTH-1:1]};
   assign w_run      = (r_state == ST_RUN);
   assign w_last     = w_run && (r_cnt == LP_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // New requests are only accepted from IDLE or DONE; i_start during RUN is ignored.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_start) begin
               w_load       = 1'b1;
               w_next_state = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.i_start) begin
               w_load       = 1'b1;
               w_next_state = ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Subtraction is a + ~b + 1, with the +1 entering through the initial carry.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_cy   <= 1'b0;
         r_cmsb <= 1'b0;
         r_cnt  <= '0;
      end else if (w_load) begin
         r_a    <= bus.i_a;
         r_b    <= bus.i_sub ? ~bus.i_b : bus.i_b;
         r_res  <= '0;
         r_cy   <= bus.i_sub;
         r_cmsb <= 1'b0;
         r_cnt  <= '0;
      end else if (w_run) begin
         r_a   <= {1'b0, r_a[WIDTH-1:1]};
         r_b   <= {1'b0, r_b[WIDTH-1:1]};
         r_res <= w_res_next;
         r_cy  <= w_fa_cout;
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_cnt == LP_MSB_IN) begin
            r_cmsb <= w_fa_cout;
         end
      end
   end

   // Result and flags move only on the final-bit edge and hold through IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b1;
      end else if (w_last) begin
         r_sum   <= w_res_next;
         r_carry <= w_fa_cout;
         r_ovf   <= r_cmsb ^ w_fa_cout;
         r_zero  <= (w_res_next == '0);
      end
   end

   assign bus.o_busy     = w_run;
   assign bus.o_done     = (r_state == ST_DONE);
   assign bus.o_sum      = r_sum;
   assign bus.o_carry    = r_carry;
   assign bus.o_overflow = r_ovf;
   assign bus.o_zero     = r_zero;
endmodule
